// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit ripple adder stepped LSB nibble first, carry kept in a register.
// Optional ADDSUB_EN build adds a subtract mode (B inverted, initial carry forced to 1).

module bit_adder (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_s,
   output logic       o_cout
);
   logic w_c1, w_c2, w_c3;

   assign o_s[0]  = i_a[0] ^ i_b[0] ^ i_cin;
   assign w_c1    = (i_a[0] & i_b[0]) | (i_cin & (i_a[0] ^ i_b[0]));
   assign o_s[1]  = i_a[1] ^ i_b[1] ^ w_c1;
   assign w_c2    = (i_a[1] & i_b[1]) | (w_c1 & (i_a[1] ^ i_b[1]));
   assign o_s[2]  = i_a[2] ^ i_b[2] ^ w_c2;
   assign w_c3    = (i_a[2] & i_b[2]) | (w_c2 & (i_a[2] ^ i_b[2]));
   assign o_s[3]  = i_a[3] ^ i_b[3] ^ w_c3;
   assign o_cout  = (i_a[3] & i_b[3]) | (w_c3 & (i_a[3] ^ i_b[3]));
endmodule

// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one nibble added per edge, index r_k walks 0..N-1
// DONE  | result presented, held until the consumer takes it
module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int N  = WIDTH / 4;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [KW-1:0]    r_k;
   logic             r_carry;
   logic             r_cout;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;

   logic [WIDTH-1:0] w_a_sh;
   logic [WIDTH-1:0] w_b_sh;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_s;
   logic             w_c;
   logic             w_init_carry;

   // Shifting by 4*k selects the active nibble without a wide multiply on the index.
   assign w_a_sh = r_a >> {r_k, 2'b00};
   assign w_b_sh = r_b >> {r_k, 2'b00};

`ifdef ADDSUB_EN
   logic r_sub;
   assign w_b_nib      = r_sub ? ~w_b_sh[3:0] : w_b_sh[3:0];
   assign w_init_carry = sub ? 1'b1 : cin;
`else
   logic w_unused_sub;
   assign w_unused_sub = sub;
   assign w_b_nib      = w_b_sh[3:0];
   assign w_init_carry = cin;
`endif

   bit_adder u_bit_adder (
      .i_a    (w_a_sh[3:0]),
      .i_b    (w_b_nib),
      .i_cin  (r_carry),
      .o_s    (w_s),
      .o_cout (w_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_k         <= '0;
         r_carry     <= 1'b0;
         r_cout      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`ifdef ADDSUB_EN
         r_sub       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_carry    <= w_init_carry;
`ifdef ADDSUB_EN
                  r_sub      <= sub;
`endif
                  r_sum      <= '0;
                  r_k        <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               for (int i = 0; i < N; i++) begin
                  if (r_k == KW'(i)) r_sum[4*i +: 4] <= w_s;
               end
               r_carry <= w_c;
               if (r_k == K_LAST) begin
                  r_cout      <= w_c;
                  r_k         <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign sum       = r_sum;
   assign cout      = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (WIDTH=16): transaction-level model checked every cycle,
// plus directed operations with literal results; subtract cases only when ADDSUB_EN is defined.

module tb_nibble_serial_adder_ctrl;
   localparam int WIDTH = 16;
   localparam int N     = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   // model: pending op, edges since accept, result of pending op, last delivered result
   bit               m_pending;
   int               m_edges;
   logic [WIDTH-1:0] m_sum;
   logic             m_cout;
   logic [WIDTH-1:0] m_last_sum;
   logic             m_last_cout;

   nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_pending   = 1'b0;
      m_edges     = 0;
      m_sum       = '0;
      m_cout      = 1'b0;
      m_last_sum  = '0;
      m_last_cout = 1'b0;
   endfunction

   function automatic void model_step(input bit rst, input bit iv, input bit ordy,
                                      input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input bit c, input bit s);
      logic [WIDTH:0] full;
      if (!rst) begin
         model_reset();
      end else if (!m_pending) begin
         if (iv) begin
            full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
`ifdef ADDSUB_EN
            if (s) full = {1'b0, x} + {1'b0, ~y} + 17'd1;
`else
            if (s && 1'b0) full = '0;
`endif
            m_sum     = full[WIDTH-1:0];
            m_cout    = full[WIDTH];
            m_pending = 1'b1;
            m_edges   = 0;
         end
      end else if (m_edges < N) begin
         m_edges++;
      end else if (ordy) begin
         m_pending   = 1'b0;
         m_last_sum  = m_sum;
         m_last_cout = m_cout;
      end
   endfunction

   task automatic check_all();
      logic [WIDTH-1:0] mask;
      logic [WIDTH-1:0] es;
      logic             eov;
      logic             ec;
      mask = '0;
      for (int i = 0; i < N; i++) if (i < m_edges) mask[4*i +: 4] = 4'hF;
      eov = m_pending && (m_edges == N);
      if (!m_pending) begin
         es = m_last_sum;  ec = m_last_cout;
      end else if (eov) begin
         es = m_sum;       ec = m_cout;
      end else begin
         es = m_sum & mask; ec = m_last_cout;
      end
      cmp("in_ready",  {31'd0, in_ready},  {31'd0, ~m_pending});
      cmp("out_valid", {31'd0, out_valid}, {31'd0, eov});
      cmp("busy",      {31'd0, busy},      {31'd0, m_pending});
      cmp("sum",       {16'd0, sum},       {16'd0, es});
      cmp("cout",      {31'd0, cout},      {31'd0, ec});
   endtask

   // inputs are stable since the previous negedge; model advances on posedge, check on negedge
   task automatic cycle();
      bit               s_rst, s_iv, s_or, s_c, s_s;
      logic [WIDTH-1:0] s_a, s_b;
      s_rst = rst_n; s_iv = in_valid; s_or = out_ready;
      s_a = a; s_b = b; s_c = cin; s_s = sub;
      @(posedge clk);
      model_step(s_rst, s_iv, s_or, s_a, s_b, s_c, s_s);
      @(negedge clk);
      cyc++;
      check_all();
   endtask

   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                         input bit tc, input bit ts, input int hold,
                         input logic [WIDTH-1:0] es, input bit ec, input string nm);
      int lat;
      a = ta; b = tb_b; cin = tc; sub = ts;
      in_valid = 1'b1; out_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         cycle();
         lat++;
      end
      cmp({nm, "_latency"}, lat, N);
      cmp({nm, "_sum"},  {16'd0, sum},  {16'd0, es});
      cmp({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
      for (int h = 0; h < hold; h++) begin
         in_valid = ((h % 2) == 0);
         cycle();
         cmp({nm, "_hold_sum"},      {16'd0, sum},      {16'd0, es});
         cmp({nm, "_hold_cout"},     {31'd0, cout},     {31'd0, ec});
         cmp({nm, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      cycle();
      cmp({nm, "_release_in_ready"}, {31'd0, in_ready}, 32'd1);
      cmp({nm, "_release_busy"},     {31'd0, busy},     32'd0);
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      int last_acc;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      cmp("reset_in_ready", {31'd0, in_ready}, 32'd1);
      cmp("reset_sum",      {16'd0, sum},      32'd0);
      rst_n = 1'b1;
      cycle();

      run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0100, 1'b0, "t1");
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, "t2a");
      run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0, 16'h5556, 1'b0, "t2b");
      run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 3, 16'hBCDE, 1'b0, "t3bp");
      cmp("t3_sum_after_idle", {16'd0, sum}, 32'h0000BCDE);

      // reset after two RUN edges
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      cmp("t4_rst_out_valid", {31'd0, out_valid}, 32'd0);
      cmp("t4_rst_sum",       {16'd0, sum},       32'd0);
      cmp("t4_rst_in_ready",  {31'd0, in_ready},  32'd1);
      cycle();
      rst_n = 1'b1;
      cycle();
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0, "t4post");

`ifdef ADDSUB_EN
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0, "t5a");
      run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 16'h0002, 1'b1, "t5b");
`endif

      // back-to-back with both handshakes held high
      in_valid = 1'b1; out_ready = 1'b1; sub = 1'b0;
      last_acc = -1;
      for (int k = 0; k < 30; k++) begin
         if (in_ready) begin
            if (last_acc >= 0) cmp("t6_interval", cyc - last_acc, N + 2);
            last_acc = cyc;
         end
         a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
         cycle();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         out_ready = 1'b1;
         cycle();
      end

      // random traffic with occasional async reset
      for (int k = 0; k < 500; k++) begin
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         cin = 1'($urandom);
         sub = 1'($urandom);
         in_valid = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 9) < 6);
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 79) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_all();
         end
         cycle();
      end
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
